// File: rtl/pid_sequencer.sv
// rtl/pid_sequencer.sv - time-shared PID controller on one signed multiplier
module pid_sequencer #(
  parameter int                          cant_bits = 13,
  parameter logic signed [cant_bits-1:0] Kp        = 13'sd18,
  parameter logic signed [cant_bits-1:0] Ki        = 13'sd2,
  parameter logic signed [cant_bits-1:0] Kd        = 13'sd4
) (
  input  logic                            Clk_G,
  input  logic                            Rst_G,
  input  logic                            Rx_En,
  input  logic signed [cant_bits-1:0]     Ref,
  input  logic signed [cant_bits-1:0]     Pot,
  input  logic                            Clr_I,
  output logic signed [2*cant_bits-1:0]   R_U,
  output logic                            Done,
  output logic                            Busy,
  output logic                            Ovr
);
  localparam int N = cant_bits;
  localparam int W = 2 * cant_bits;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ERR  = 3'd1,
    S_MP   = 3'd2,
    S_MI   = 3'd3,
    S_MD   = 3'd4,
    S_OUT  = 3'd5
  } state_t;

  state_t state, state_next;

  logic signed [N-1:0] ref_q, pot_q, e, e_prev, i_e, d;
  logic signed [W-1:0] acc;
  logic                pend;

  logic signed [N-1:0] diff, i_e_next, d_next, mul_a, mul_b;
  logic signed [W-1:0] a_ext, b_ext, prod;
  logic signed [W:0]   sum;
  logic                accept, clr, done_next, busy_next, ovr_next;

  // Saturate a value one bit wider than the target: overflow iff the top two bits differ.
  function automatic logic signed [N-1:0] sat_n(input logic signed [N:0] x);
    if (x[N] != x[N-1]) sat_n = x[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    else                sat_n = x[N-1:0];
  endfunction

  function automatic logic signed [W-1:0] sat_w(input logic signed [W:0] x);
    if (x[W] != x[W-1]) sat_w = x[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else                sat_w = x[W-1:0];
  endfunction

  assign diff     = sat_n({ref_q[N-1], ref_q} - {pot_q[N-1], pot_q});
  assign i_e_next = sat_n({i_e[N-1], i_e} + {diff[N-1], diff});
  assign d_next   = sat_n({diff[N-1], diff} - {e_prev[N-1], e_prev});

  always_comb begin
    mul_a = Kp;
    mul_b = e;
    case (state)
      S_MI: begin mul_a = Ki; mul_b = i_e; end
      S_MD: begin mul_a = Kd; mul_b = d;   end
      default: ;
    endcase
  end

  assign a_ext = {{N{mul_a[N-1]}}, mul_a};
  assign b_ext = {{N{mul_b[N-1]}}, mul_b};
  assign prod  = a_ext * b_ext;
  assign sum   = {acc[W-1], acc} + {prod[W-1], prod};

  // A sample is captured into ref_q/pot_q first; the FSM picks it up from pend next cycle.
  assign accept = Rx_En && (state == S_IDLE) && !pend;
  assign clr    = Clr_I && !Rx_En && (state == S_IDLE) && !pend;

  always_ff @(posedge Clk_G or posedge Rst_G) begin
    if (Rst_G) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = S_IDLE;
    case (state)
      S_IDLE:  state_next = pend ? S_ERR : S_IDLE;
      S_ERR:   state_next = S_MP;
      S_MP:    state_next = S_MI;
      S_MI:    state_next = S_MD;
      S_MD:    state_next = S_OUT;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    done_next = (state == S_OUT);
    busy_next = (state_next != S_IDLE);
    ovr_next  = Rx_En && ((state != S_IDLE) || pend);
  end

  always_ff @(posedge Clk_G or posedge Rst_G) begin
    if (Rst_G) begin
      ref_q  <= '0;
      pot_q  <= '0;
      e      <= '0;
      e_prev <= '0;
      i_e    <= '0;
      d      <= '0;
      acc    <= '0;
      pend   <= 1'b0;
      R_U    <= '0;
      Done   <= 1'b0;
      Busy   <= 1'b0;
      Ovr    <= 1'b0;
    end else begin
      Done <= done_next;
      Busy <= busy_next;
      Ovr  <= ovr_next;
      if (accept) begin
        ref_q <= Ref;
        pot_q <= Pot;
        pend  <= 1'b1;
      end else if (state == S_IDLE && pend) begin
        pend  <= 1'b0;
      end
      if (clr) begin
        i_e    <= '0;
        e_prev <= '0;
      end
      case (state)
        S_ERR: begin
          e   <= diff;
          i_e <= i_e_next;
          d   <= d_next;
        end
        S_MP:  acc <= prod;
        S_MI:  acc <= sat_w(sum);
        S_MD:  acc <= sat_w(sum);
        S_OUT: begin
          R_U    <= acc;
          e_prev <= e;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pid_sequencer.sv
// tb/tb_pid_sequencer.sv - randomized self-checking bench for pid_sequencer
module tb_pid_sequencer;
  logic               Clk_G = 1'b0;
  logic               Rst_G = 1'b1;
  logic               Rx_En = 1'b0;
  logic signed [12:0] Ref = '0;
  logic signed [12:0] Pot = '0;
  logic               Clr_I = 1'b0;
  logic signed [25:0] R_U;
  logic               Done, Busy, Ovr;

  int checks = 0;
  int errors = 0;

  longint m_i = 0;
  longint m_eprev = 0;

  pid_sequencer dut (
    .Clk_G(Clk_G), .Rst_G(Rst_G), .Rx_En(Rx_En), .Ref(Ref), .Pot(Pot),
    .Clr_I(Clr_I), .R_U(R_U), .Done(Done), .Busy(Busy), .Ovr(Ovr)
  );

  always #5 Clk_G = ~Clk_G;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sat(input longint x, input int bits);
    longint hi, lo;
    hi = (longint'(1) <<< (bits - 1)) - 1;
    lo = -(longint'(1) <<< (bits - 1));
    return (x > hi) ? hi : (x < lo) ? lo : x;
  endfunction

  // Reference PID step computed from the control law with plain integer arithmetic.
  function automatic longint model_step(input longint r, input longint p);
    longint e, d, u;
    e       = sat(r - p, 13);
    m_i     = sat(m_i + e, 13);
    d       = sat(e - m_eprev, 13);
    u       = sat(sat(18 * e + 2 * m_i, 26) + 4 * d, 26);
    m_eprev = e;
    return u;
  endfunction

  task automatic model_clear();
    m_i = 0;
    m_eprev = 0;
  endtask

  // Drive one sample, then follow it through to Done checking latency, Busy and R_U.
  task automatic run_sample(input string tag, input int r, input int p, input bit clr_busy);
    longint exp_u;
    int cycles, busy_cnt;
    exp_u = model_step(r, p);
    @(negedge Clk_G);
    Rx_En = 1'b1; Ref = r[12:0]; Pot = p[12:0]; Clr_I = clr_busy;
    @(negedge Clk_G);
    Rx_En = 1'b0;
    cycles = 0; busy_cnt = 0;
    while (!Done && cycles < 20) begin
      if (Busy) busy_cnt++;
      @(negedge Clk_G);
      cycles++;
      if (cycles == 4) Clr_I = 1'b0;
    end
    Clr_I = 1'b0;
    check({tag, "_latency"}, cycles, 6);
    check({tag, "_busycnt"}, busy_cnt, 5);
    check({tag, "_ru"}, R_U, exp_u);
    check({tag, "_busy_at_done"}, Busy, 0);
    @(negedge Clk_G);
    check({tag, "_done_width"}, Done, 0);
    check({tag, "_ru_hold"}, R_U, exp_u);
  endtask

  initial begin
    longint exp_u;
    int done_cnt, r, p;

    #12;
    check("reset_ru", R_U, 0);
    check("reset_done", Done, 0);
    check("reset_busy", Busy, 0);
    check("reset_ovr", Ovr, 0);
    @(negedge Clk_G);
    Rst_G = 1'b0;

    run_sample("first", 100, 0, 1'b0);
    check("first_abs", R_U, 2400);
    run_sample("second", 100, 0, 1'b0);
    check("second_abs", R_U, 2200);

    @(negedge Clk_G); Clr_I = 1'b1;
    @(negedge Clk_G); Clr_I = 1'b0;
    model_clear();
    run_sample("after_clr", 100, 0, 1'b0);
    check("after_clr_abs", R_U, 2400);

    @(negedge Clk_G); Clr_I = 1'b1;
    @(negedge Clk_G); Clr_I = 1'b0;
    model_clear();
    run_sample("sat1", 4095, -4096, 1'b0);
    check("sat1_abs", R_U, 98280);
    run_sample("sat2", 4095, -4096, 1'b0);

    // Overrun: second strobe arrives mid-computation and must be dropped.
    exp_u = model_step(37, -20);
    @(negedge Clk_G);
    Rx_En = 1'b1; Ref = 13'sd37; Pot = -13'sd20;
    @(negedge Clk_G); Rx_En = 1'b0;
    @(negedge Clk_G);
    @(negedge Clk_G);
    Rx_En = 1'b1; Ref = 13'sd500; Pot = 13'sd0;
    @(negedge Clk_G); Rx_En = 1'b0;
    check("ovr_pulse", Ovr, 1);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk_G);
      if (i == 0) check("ovr_width", Ovr, 0);
      if (Done) begin
        done_cnt++;
        check("ovr_ru", R_U, exp_u);
      end
    end
    check("ovr_done_cnt", done_cnt, 1);

    // Reset mid-run aborts without Done.
    @(negedge Clk_G);
    Rx_En = 1'b1; Ref = 13'sd100; Pot = 13'sd0;
    @(negedge Clk_G); Rx_En = 1'b0;
    @(negedge Clk_G);
    @(negedge Clk_G);
    Rst_G = 1'b1;
    #1;
    check("rst_busy", Busy, 0);
    check("rst_ru", R_U, 0);
    model_clear();
    @(negedge Clk_G); Rst_G = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk_G);
      if (Done) done_cnt++;
    end
    check("rst_no_done", done_cnt, 0);
    check("rst_ru_hold", R_U, 0);
    run_sample("post_rst", 100, 0, 1'b0);
    check("post_rst_abs", R_U, 2400);

    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(8191)) - 4096;
      p = int'($urandom_range(8191)) - 4096;
      if ($urandom_range(7) == 0) begin
        r = r / 64;
        p = p / 64;
      end
      if ($urandom_range(5) == 0) begin
        @(negedge Clk_G); Clr_I = 1'b1;
        @(negedge Clk_G); Clr_I = 1'b0;
        model_clear();
      end
      run_sample($sformatf("rnd%0d", n), r, p, $urandom_range(3) == 0);
      for (int g = 0; g < int'($urandom_range(2)); g++) @(negedge Clk_G);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
